nes_mem_sched: RTL and testbench

Scheduler for the single-port 16-bit SPRAM that backs NES PRG/CHR memory on the iCE40 UP5K build.

---
 rtl/nes_mem_pkg.sv | 19 +
 rtl/nes_byte_lane.sv | 18 +
 rtl/nes_mem_sched.sv | 96 +++++++++
 tb/tb_nes_mem_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_mem_pkg.sv
// Shared constants and types for the NES SPRAM scheduler.
// Covers default widths, byte-lane write masks, the open-bus byte and the pending-read record.
package nes_mem_pkg;

  localparam int unsigned RAM_AW_DEFAULT   = 16;
  localparam int unsigned NES_AW_DEFAULT   = 22;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'hFF;

  localparam logic [3:0] MASK_LO = 4'b0011;
  localparam logic [3:0] MASK_HI = 4'b1100;

  typedef struct packed {
    logic cpu;
    logic ppu;
    logic hi;
    logic in_range;
  } rd_pend_t;

endpackage

// File: rtl/nes_byte_lane.sv
// Byte-lane steering for the 16-bit SPRAM.
// Produces the nibble write mask for the addressed byte and selects the read byte.
module nes_byte_lane
  import nes_mem_pkg::*;
(
  input  logic        wr_sel,
  input  logic        rd_sel,
  input  logic [15:0] rdata,
  output logic [3:0]  mask,
  output logic [7:0]  rbyte
);

  always_comb begin
    mask  = wr_sel ? MASK_HI : MASK_LO;
    rbyte = rd_sel ? rdata[15:8] : rdata[7:0];
  end

endmodule

// File: rtl/nes_mem_sched.sv
// Single-port SPRAM scheduler: one NES slot per clock-enable period, loader bytes otherwise.
// NES reads are captured one cycle after the slot into held per-requester registers.
module nes_mem_sched
  import nes_mem_pkg::*;
#(
  parameter int unsigned RAM_AW   = RAM_AW_DEFAULT,
  parameter int unsigned NES_AW   = NES_AW_DEFAULT,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run_nes,
  input  logic              loading,
  input  logic [NES_AW-1:0] nes_addr,
  input  logic              nes_rd_cpu,
  input  logic              nes_rd_ppu,
  input  logic              nes_wr,
  input  logic [7:0]        nes_wdata,
  output logic [7:0]        nes_q_cpu,
  output logic [7:0]        nes_q_ppu,
  input  logic              ldr_valid,
  output logic              ldr_ready,
  input  logic [RAM_AW:0]   ldr_addr,
  input  logic [7:0]        ldr_data,
  output logic [RAM_AW+1:0] ldr_count,
  output logic              oob_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic [3:0]        ram_maskwren,
  output logic              ram_wren,
  input  logic [15:0]       ram_rdata
);

  localparam logic [RAM_AW+1:0] CountOne = {{(RAM_AW+1){1'b0}}, 1'b1};

  logic     run_d;
  rd_pend_t rd_pend, rd_pend_next;
  logic     nes_req, in_range, ldr_xfer, lane_sel;
  logic [7:0] rd_byte, cap_byte;

  // Any set bit above the RAM's byte range means the access misses the SPRAM.
  assign in_range = (nes_addr[NES_AW-1:RAM_AW+1] == '0);

  nes_byte_lane u_byte_lane (
    .wr_sel (lane_sel),
    .rd_sel (rd_pend.hi),
    .rdata  (ram_rdata),
    .mask   (ram_maskwren),
    .rbyte  (rd_byte)
  );

  always_comb begin
    nes_req   = run_d & ~loading & (nes_rd_cpu | nes_rd_ppu | nes_wr);
    ldr_ready = resetn & ~nes_req;
    ldr_xfer  = ldr_valid & ldr_ready;

    if (nes_req) begin
      ram_addr  = nes_addr[RAM_AW:1];
      lane_sel  = nes_addr[0];
      ram_wdata = {nes_wdata, nes_wdata};
      ram_wren  = resetn & nes_wr & in_range;
    end else begin
      ram_addr  = ldr_addr[RAM_AW:1];
      lane_sel  = ldr_addr[0];
      ram_wdata = {ldr_data, ldr_data};
      ram_wren  = ldr_xfer;
    end

    rd_pend_next = '0;
    if (nes_req && !nes_wr) begin
      rd_pend_next = '{cpu: nes_rd_cpu, ppu: nes_rd_ppu, hi: nes_addr[0], in_range: in_range};
    end

    cap_byte = rd_pend.in_range ? rd_byte : OPEN_BUS;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      run_d     <= 1'b0;
      rd_pend   <= '0;
      nes_q_cpu <= 8'h00;
      nes_q_ppu <= 8'h00;
      ldr_count <= '0;
      oob_err   <= 1'b0;
    end else begin
      run_d   <= run_nes;
      rd_pend <= rd_pend_next;
      // Capture of the previous slot overlaps a back-to-back slot; rd_pend is a single stage.
      if (rd_pend.cpu) nes_q_cpu <= cap_byte;
      if (rd_pend.ppu) nes_q_ppu <= cap_byte;
      if (ldr_xfer && (ldr_count != '1)) ldr_count <= ldr_count + CountOne;
      if (nes_req && !in_range) oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nes_mem_sched.sv
// Bench for nes_mem_sched with a byte-array reference model and a behavioural SPRAM.
// Uses a small RAM so out-of-range addresses and counter saturation are reachable.
module tb_nes_mem_sched;

  localparam int unsigned RAM_AW = 4;
  localparam int unsigned NES_AW = 22;
  localparam int unsigned BYTES  = 1 << (RAM_AW + 1);
  localparam int unsigned CMAX   = (1 << (RAM_AW + 2)) - 1;

  logic              clock = 1'b0;
  logic              resetn, run_nes, loading;
  logic [NES_AW-1:0] nes_addr;
  logic              rd_cpu, rd_ppu, wr;
  logic [7:0]        nes_wdata, nes_q_cpu, nes_q_ppu;
  logic              ldr_valid, ldr_ready;
  logic [RAM_AW:0]   ldr_addr;
  logic [7:0]        ldr_data;
  logic [RAM_AW+1:0] ldr_count;
  logic              oob_err;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_wdata, ram_rdata;
  logic [3:0]        ram_maskwren;
  logic              ram_wren;

  always #5 clock = ~clock;

  nes_mem_sched #(.RAM_AW(RAM_AW), .NES_AW(NES_AW), .OPEN_BUS(8'hFF)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .run_nes      (run_nes),
    .loading      (loading),
    .nes_addr     (nes_addr),
    .nes_rd_cpu   (rd_cpu),
    .nes_rd_ppu   (rd_ppu),
    .nes_wr       (wr),
    .nes_wdata    (nes_wdata),
    .nes_q_cpu    (nes_q_cpu),
    .nes_q_ppu    (nes_q_ppu),
    .ldr_valid    (ldr_valid),
    .ldr_ready    (ldr_ready),
    .ldr_addr     (ldr_addr),
    .ldr_data     (ldr_data),
    .ldr_count    (ldr_count),
    .oob_err      (oob_err),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_maskwren (ram_maskwren),
    .ram_wren     (ram_wren),
    .ram_rdata    (ram_rdata)
  );

  // Behavioural SPRAM: nibble-masked write, registered read of the pre-write contents.
  logic [15:0] spram [1 << RAM_AW];
  always @(posedge clock) begin
    logic [15:0] w;
    w = spram[ram_addr];
    ram_rdata <= w;
    if (ram_wren) begin
      for (int i = 0; i < 4; i++) if (ram_maskwren[i]) w[4*i +: 4] = ram_wdata[4*i +: 4];
      spram[ram_addr] <= w;
    end
  end

  // Reference model state, in byte terms.
  logic [7:0] mem_ref [BYTES];
  logic       m_run, m_pend, m_pcpu, m_pppu, m_oob;
  logic [7:0] m_pbyte, m_q_cpu, m_q_ppu;
  int         m_count;
  logic       last_xfer;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Check one cycle against the rules, clock it, then advance the model.
  task automatic cycle();
    logic req, in_rng, xfer, exp_wren, sel;
    int unsigned na;
    na     = int'(nes_addr);
    in_rng = na < BYTES;
    req    = m_run && !loading && (rd_cpu || rd_ppu || wr);
    #1;
    chk("q_cpu", nes_q_cpu, m_q_cpu);
    chk("q_ppu", nes_q_ppu, m_q_ppu);
    chk("count", ldr_count, m_count);
    chk("oob", oob_err, m_oob);
    if (!resetn) begin
      xfer = 1'b0;
      chk("ready_rst", ldr_ready, 1'b0);
      chk("wren_rst", ram_wren, 1'b0);
    end else begin
      xfer = ldr_valid && !req;
      chk("ready", ldr_ready, !req);
      if (req) begin
        exp_wren = wr && in_rng;
        sel      = nes_addr[0];
        chk("addr_nes", ram_addr, nes_addr[RAM_AW:1]);
        if (exp_wren) chk("wdata_nes", ram_wdata, {nes_wdata, nes_wdata});
      end else begin
        exp_wren = xfer;
        sel      = ldr_addr[0];
        chk("addr_ldr", ram_addr, ldr_addr[RAM_AW:1]);
        if (exp_wren) chk("wdata_ldr", ram_wdata, {ldr_data, ldr_data});
      end
      chk("wren", ram_wren, exp_wren);
      if (exp_wren) chk("mask", ram_maskwren, sel ? 4'b1100 : 4'b0011);
    end
    @(posedge clock);
    #1;
    if (!resetn) begin
      m_run = 0; m_pend = 0; m_q_cpu = 0; m_q_ppu = 0; m_count = 0; m_oob = 0;
    end else begin
      if (m_pend) begin
        if (m_pcpu) m_q_cpu = m_pbyte;
        if (m_pppu) m_q_ppu = m_pbyte;
      end
      m_pend = req && !wr;
      if (m_pend) begin
        m_pcpu  = rd_cpu;
        m_pppu  = rd_ppu;
        m_pbyte = in_rng ? mem_ref[na] : 8'hFF;
      end
      if (req && wr && in_rng) mem_ref[na] = nes_wdata;
      if (xfer) begin
        mem_ref[ldr_addr] = ldr_data;
        if (m_count < CMAX) m_count++;
      end
      if (req && !in_rng) m_oob = 1'b1;
      m_run = run_nes;
    end
    last_xfer = xfer;
  endtask

  task automatic nes_idle();
    rd_cpu = 0; rd_ppu = 0; wr = 0; run_nes = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << RAM_AW); i++) spram[i] = 16'h0000;
    for (int i = 0; i < BYTES; i++) mem_ref[i] = 8'h00;
    m_run = 0; m_pend = 0; m_pcpu = 0; m_pppu = 0; m_oob = 0;
    m_pbyte = 0; m_q_cpu = 0; m_q_ppu = 0; m_count = 0; last_xfer = 0;
    resetn = 0; loading = 0; nes_addr = '0; nes_wdata = 0; nes_idle();
    ldr_valid = 1; ldr_addr = 0; ldr_data = 8'h77;
    @(posedge clock);
    #1;

    // Reset with loader pressure and random NES activity.
    for (int i = 0; i < 3; i++) begin
      run_nes = 1'($urandom_range(0, 1)); rd_cpu = 1'($urandom_range(0, 1));
      cycle();
    end
    resetn = 1; nes_idle();

    // Loader burst while loading; NES requests must be dropped.
    loading = 1;
    for (int i = 0; i < 8; i++) begin
      ldr_addr = 5'(i); ldr_data = 8'(8'h10 + i);
      run_nes = (i % 4 == 0); rd_cpu = 1; nes_addr = 22'd3;
      cycle();
    end
    chk("p1_count", ldr_count, 8);
    chk("p1_q_cpu", nes_q_cpu, 8'h00);
    nes_idle(); ldr_valid = 0; loading = 0;
    cycle();

    // CPU read of byte 5 (high byte of word 2).
    nes_addr = 22'd5; rd_cpu = 1;
    for (int c = 0; c < 8; c++) begin run_nes = (c % 4 == 0); cycle(); end
    chk("p2_q_cpu", nes_q_cpu, 8'h15);
    chk("p2_q_ppu", nes_q_ppu, 8'h00);

    // Write beats read, then PPU reads the written byte back.
    nes_addr = 22'd2; wr = 1; rd_cpu = 1; nes_wdata = 8'hA5;
    for (int c = 0; c < 4; c++) begin run_nes = (c == 0); cycle(); end
    chk("p4_q_cpu", nes_q_cpu, 8'h15);
    wr = 0; rd_cpu = 0; rd_ppu = 1;
    for (int c = 0; c < 4; c++) begin run_nes = (c == 0); cycle(); end
    chk("p4_q_ppu", nes_q_ppu, 8'hA5);
    nes_idle();

    // Contention: loader always valid, NES reads every slot.
    ldr_valid = 1; ldr_addr = 5'd8; ldr_data = 8'($urandom);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      run_nes = (c % 4 == 0);
      if (c % 4 == 0) begin
        nes_addr = 22'($urandom_range(0, BYTES - 1));
        rd_cpu = 1'($urandom_range(0, 1)); rd_ppu = !rd_cpu || 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_xfer) begin n++; ldr_addr = ldr_addr + 5'd1; ldr_data = 8'($urandom); end
    end
    chk("p3_count", ldr_count, 38);
    nes_idle(); ldr_valid = 0;

    // Out of range read, then out of range write.
    nes_addr = 22'd32; rd_cpu = 1;
    for (int c = 0; c < 4; c++) begin run_nes = (c == 0); cycle(); end
    chk("p5_q_cpu", nes_q_cpu, 8'hFF);
    chk("p5_oob", oob_err, 1'b1);
    nes_addr = 22'd40; rd_cpu = 0; wr = 1; nes_wdata = 8'h3C;
    for (int c = 0; c < 4; c++) begin run_nes = (c == 0); cycle(); end
    nes_idle();

    // Random traffic with irregular run_nes; loader inputs only change after a transfer.
    for (int c = 0; c < 400; c++) begin
      loading   = ($urandom_range(0, 9) == 0);
      run_nes   = ($urandom_range(0, 2) == 0);
      rd_cpu    = 1'($urandom_range(0, 1));
      rd_ppu    = 1'($urandom_range(0, 1));
      wr        = ($urandom_range(0, 3) == 0);
      nes_addr  = 22'($urandom_range(0, BYTES + 15));
      nes_wdata = 8'($urandom);
      if (last_xfer || !ldr_valid) begin
        ldr_valid = 1'($urandom_range(0, 1));
        ldr_addr  = 5'($urandom);
        ldr_data  = 8'($urandom);
      end
      cycle();
    end

    // Counter saturation.
    nes_idle(); loading = 1; ldr_valid = 1;
    for (int c = 0; c < CMAX + 8; c++) begin
      ldr_addr = 5'($urandom); ldr_data = 8'($urandom);
      cycle();
    end
    chk("sat_count", ldr_count, CMAX);

    // Reset in the middle of a burst, then resume.
    ldr_addr = 5'd1; ldr_data = 8'h5A; resetn = 0;
    cycle();
    chk("p6_count", ldr_count, 0);
    chk("p6_q_cpu", nes_q_cpu, 8'h00);
    chk("p6_q_ppu", nes_q_ppu, 8'h00);
    chk("p6_oob", oob_err, 1'b0);
    resetn = 1;
    cycle();
    chk("p6_resume", ldr_count, 1);
    loading = 0; ldr_valid = 0;
    rd_cpu = 1; nes_addr = 22'd1;
    for (int c = 0; c < 4; c++) begin run_nes = (c == 0); cycle(); end
    chk("p6_readback", nes_q_cpu, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
